// File: rtl/hamming_checker_secded_pkg.sv
// Shared width derivations and data-bit placement for the SECDED checker.
package hamming_checker_secded_pkg;

    // Index of the codeword MSB for p Hamming parity bits.
    function automatic int ip_width(input int p);
        return (1 << p) - 1;
    endfunction

    // Number of data bits carried by a codeword with p Hamming parity bits.
    function automatic int op_width(input int p);
        return (1 << p) - p - 1;
    endfunction

    // Codeword position of data bit idx: the idx-th non-power-of-two position >= 3.
    function automatic int data_pos(input int p, input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int k = 3; k < (1 << p); k++) begin
            if ((k & (k - 1)) != 0) begin
                if (cnt == idx) pos = k;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_checker_secded_syndrome.sv
// Combinational syndrome and overall-parity computation for an extended Hamming codeword.
module hamming_syndrome
    import hamming_checker_secded_pkg::*;
#(
    parameter int P_BITS = 3,
    localparam int IP_WIDTH = ip_width(P_BITS)
) (
    input  logic [IP_WIDTH:0]  ip,
    output logic [P_BITS-1:0]  syn,
    output logic               ovr
);

    // Syndrome bit j covers every position whose index has bit j set.
    for (genvar j = 0; j < P_BITS; j++) begin : g_syn
        logic [IP_WIDTH:0] sel;
        for (genvar k = 0; k <= IP_WIDTH; k++) begin : g_bit
            if (((k >> j) & 1) == 1) begin : g_on
                assign sel[k] = ip[k];
            end else begin : g_off
                assign sel[k] = 1'b0;
            end
        end
        assign syn[j] = ^sel;
    end

    // Overall parity spans the whole codeword, including bit 0.
    assign ovr = ^ip;

endmodule

// File: rtl/hamming_checker_secded.sv
// Registered SECDED decoder: syndrome, overall parity, corrected data and error flags.
module hamming_checker_secded
    import hamming_checker_secded_pkg::*;
#(
    parameter int P_BITS = 3,
    localparam int IP_WIDTH = ip_width(P_BITS),
    localparam int OP_WIDTH = op_width(P_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [IP_WIDTH:0]   ip,
    output logic                out_valid,
    output logic [OP_WIDTH-1:0] data,
    output logic [P_BITS:0]     par,
    output logic                single_err,
    output logic                double_err
);

    logic [P_BITS-1:0]   syn;
    logic                ovr;
    logic [OP_WIDTH-1:0] data_nxt;
    logic                single_nxt;
    logic                double_nxt;

    hamming_syndrome #(.P_BITS(P_BITS)) u_syndrome (
        .ip  (ip),
        .syn (syn),
        .ovr (ovr)
    );

    // A data bit is flipped only when the single-error syndrome points at its position;
    // an overall-parity-only error leaves S=0, which matches no data position.
    for (genvar i = 0; i < OP_WIDTH; i++) begin : g_data
        localparam int POS = data_pos(P_BITS, i);
        assign data_nxt[i] = ip[POS] ^ (ovr && (syn == P_BITS'(POS)));
    end

    assign single_nxt = ovr;
    assign double_nxt = ~ovr & (|syn);

    // Output register: results captured on valid, flags cleared and data/par held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            data       <= '0;
            par        <= '0;
            single_err <= 1'b0;
            double_err <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data       <= data_nxt;
                par        <= {ovr, syn};
                single_err <= single_nxt;
                double_err <= double_nxt;
            end else begin
                single_err <= 1'b0;
                double_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_checker_secded.sv
// Directed and sweep checks of the SECDED checker at P_BITS=3 and P_BITS=4.
module tb_hamming_checker_secded;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  par;
        logic        se;
        logic        de;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv3;
    logic [7:0]  ip3;
    logic        ov3;
    logic [3:0]  d3;
    logic [3:0]  p3;
    logic        se3;
    logic        de3;

    logic        iv4;
    logic [15:0] ip4;
    logic        ov4;
    logic [10:0] d4;
    logic [4:0]  p4;
    logic        se4;
    logic        de4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_checker_secded #(.P_BITS(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv3),
        .ip         (ip3),
        .out_valid  (ov3),
        .data       (d3),
        .par        (p3),
        .single_err (se3),
        .double_err (de3)
    );

    hamming_checker_secded #(.P_BITS(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv4),
        .ip         (ip4),
        .out_valid  (ov4),
        .data       (d4),
        .par        (p4),
        .single_err (se4),
        .double_err (de4)
    );

    // Behavioural SECDED decode: syndrome as XOR of set indices.
    function automatic res_t model(input int p, input logic [63:0] cw_in);
        res_t r;
        logic [63:0] cw;
        int s;
        logic o;
        int n;
        int idx;
        cw = cw_in;
        s = 0;
        o = 1'b0;
        n = (1 << p) - 1;
        for (int k = 0; k <= n; k++) begin
            o ^= cw[k];
            if (k > 0 && cw[k]) s ^= k;
        end
        r = '0;
        r.par = 8'(s) | (8'(o) << p);
        if (o) begin
            r.se = 1'b1;
            if (s != 0) cw[s] = ~cw[s];
        end else if (s != 0) begin
            r.de = 1'b1;
        end
        idx = 0;
        for (int k = 3; k <= n; k++) begin
            if ((k & (k - 1)) != 0) begin
                r.data[idx] = cw[k];
                idx++;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic directed3(input string tag, input logic [7:0] cw, input logic [3:0] ed,
                             input logic [3:0] ep, input logic es, input logic ee);
        @(negedge clk);
        ip3 = cw;
        iv3 = 1'b1;
        @(negedge clk);
        check({tag, "_vld"},  32'(ov3), 32'd1);
        check({tag, "_data"}, 32'(d3),  32'(ed));
        check({tag, "_par"},  32'(p3),  32'(ep));
        check({tag, "_se"},   32'(se3), 32'(es));
        check({tag, "_de"},   32'(de3), 32'(ee));
    endtask

    initial begin
        res_t m;
        res_t prev;
        logic [15:0] prev4;

        rst = 1'b1;
        iv3 = 1'b0;
        ip3 = '0;
        iv4 = 1'b0;
        ip4 = '0;
        #1;
        check("rst_out3", {27'd0, ov3, d3, p3, se3, de3}, 32'd0);
        check("rst_out4", {12'd0, ov4, d4, p4, se4, de4}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        directed3("clean",    8'hAA, 4'hB, 4'h0, 1'b0, 1'b0);
        directed3("sgl_data", 8'h8A, 4'hB, 4'hD, 1'b1, 1'b0);
        directed3("sgl_ovr",  8'hAB, 4'hB, 4'h8, 1'b1, 1'b0);
        directed3("dbl",      8'hCA, 4'hD, 4'h3, 1'b0, 1'b1);

        // Idle cycle: valid drops, flags clear, data and par hold.
        iv3 = 1'b0;
        ip3 = 8'h8A;
        @(negedge clk);
        check("idle_vld",   32'(ov3), 32'd0);
        check("idle_hold",  {24'd0, d3, p3}, {24'd0, 4'hD, 4'h3});
        check("idle_flags", {30'd0, se3, de3}, 32'd0);

        // Back-to-back sweep of every 8-bit codeword.
        prev = '0;
        for (int i = 0; i <= 256; i++) begin
            if (i > 0) begin
                check("sw3_vld",  32'(ov3), 32'd1);
                check("sw3_data", 32'(d3),  32'(prev.data));
                check("sw3_par",  32'(p3),  32'(prev.par));
                check("sw3_flag", {30'd0, se3, de3}, {30'd0, prev.se, prev.de});
            end
            if (i < 256) begin
                ip3 = 8'(i);
                iv3 = 1'b1;
                prev = model(3, 64'(i));
            end else begin
                iv3 = 1'b0;
            end
            @(negedge clk);
        end

        // Back-to-back random codewords at P_BITS=4.
        prev = '0;
        for (int i = 0; i <= 300; i++) begin
            if (i > 0) begin
                check("sw4_vld",  32'(ov4), 32'd1);
                check("sw4_data", 32'(d4),  32'(prev.data[10:0]));
                check("sw4_par",  32'(p4),  32'(prev.par[4:0]));
                check("sw4_flag", {30'd0, se4, de4}, {30'd0, prev.se, prev.de});
            end
            if (i < 300) begin
                prev4 = 16'($urandom);
                if (i < 16) prev4 = 16'h0001 << i;
                ip4 = prev4;
                iv4 = 1'b1;
                prev = model(4, 64'(prev4));
            end else begin
                iv4 = 1'b0;
            end
            @(negedge clk);
        end

        // Reset in the middle of a stream.
        for (int i = 0; i < 5; i++) begin
            ip3 = 8'hFF - 8'(i);
            iv3 = 1'b1;
            ip4 = 16'h1234 + 16'(i);
            iv4 = 1'b1;
            @(negedge clk);
        end
        m = model(3, 64'hFB);
        check("pre_rst_par", 32'(p3), 32'(m.par));
        rst = 1'b1;
        #1;
        check("mid_rst3", {27'd0, ov3, d3, p3, se3, de3}, 32'd0);
        check("mid_rst4", {12'd0, ov4, d4, p4, se4, de4}, 32'd0);
        @(negedge clk);
        check("hold_rst3", {27'd0, ov3, d3, p3, se3, de3}, 32'd0);
        rst = 1'b0;
        iv4 = 1'b0;
        ip3 = 8'hAA;
        iv3 = 1'b1;
        @(negedge clk);
        check("post_rst_vld",  32'(ov3), 32'd1);
        check("post_rst_data", 32'(d3),  32'hB);
        check("post_rst_ov4",  32'(ov4), 32'd0);
        iv3 = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_checker_secded.md
# hamming_checker_secded

Registered extended-Hamming (SECDED) decoder/checker, parameterised by the number of Hamming parity bits. It accepts one 2^P_BITS-bit codeword per cycle and reports the syndrome and overall parity. It also returns the extracted data bits, corrected when a single-bit error is detected, and flags single or double errors. It sits on the receive side of any link or memory protected by the matching `hamming_checker` encoder format, one register stage after the codeword source.

## Interface
- `P_BITS`, default 3: number of Hamming parity bits; legal range 2..6.
- `IP_WIDTH`, derived: 2^P_BITS − 1. It is the index of the codeword MSB.
- `OP_WIDTH`, derived: 2^P_BITS − P_BITS − 1. It is the number of data bits.
- `clk`, input, 1: single clock; all state on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: `ip` is sampled this cycle.
- `ip`, input, IP_WIDTH+1: codeword. Bit 0 is overall parity, and bit k (k ≥ 1) is Hamming position k.
- `out_valid`, output, 1: outputs correspond to a sampled codeword.
- `data`, output, OP_WIDTH: data bits, corrected on a single-bit error.
- `par`, output, P_BITS+1: check result. `par[P_BITS-1:0]` is the syndrome and `par[P_BITS]` is the overall parity.
- `single_err`, output, 1: correctable error detected.
- `double_err`, output, 1: uncorrectable double error detected.

## Operation
- **Syndrome:** S = XOR of the indices k (1..IP_WIDTH) for which `ip[k]`=1. Equivalently, S[j] = XOR of `ip[k]` over k with bit j of k set.
- **Overall parity:** O = XOR of all `ip` bits, including bit 0.
- **par:** `par` = {O, S}.
- **Data positions:** these are the non-power-of-two positions k ≥ 3, in ascending order. `data[0]` maps to the lowest such k. For P_BITS=3 the mapping is `data[3:0]` = {`ip[7]`, `ip[6]`, `ip[5]`, `ip[3]`}.
- **Classification:**
  - S=0, O=0: clean. `data` = raw bits; both error flags 0.
  - O=1: single error, `single_err`=1. If S≠0, bit S is inverted before data extraction. If S=0, the error is in bit 0 and the data is unchanged.
  - S≠0, O=0: double error, `double_err`=1. `data` = raw, uncorrected bits.
- `single_err` and `double_err` are never both 1.

## Timing
- All outputs are registered, with one cycle of latency. `ip` is sampled at edge N when `in_valid`=1, and the results are visible after edge N, together with `out_valid`=1.
- If `in_valid`=0 at an edge, then `out_valid` goes to 0 at that edge. `data` and `par` hold their previous values, and both error flags go to 0.
- Back-to-back valid codewords are accepted every cycle. There is no backpressure.
- Reset drives every output to 0 immediately, including in the middle of a stream. The first valid result appears one edge after `rst` deasserts and `in_valid`=1.

## Structure
- A shared package holds:
  - the width derivations `IP_WIDTH(P)` and `OP_WIDTH(P)` as constant functions;
  - a constant function that maps a data index to its codeword position.
- One combinational sub-module, `hamming_syndrome` (`ip` → S, O), built from generate loops. The top level adds the correction mux, data extraction, classification and output registers.
- Widths must not be hard-coded anywhere. Everything derives from `P_BITS`.

## Test plan
Unless stated otherwise, each case uses P_BITS=3 and `in_valid`=1, and results are checked one cycle after the codeword is sampled.
- **Clean codeword:** `ip`=8'hAA gives `par`=4'h0 and `data`=4'hB, with no error flags.
- **Single error in a data bit:** `ip`=8'h8A (bit 5 flipped) gives `par`=4'hD, `data`=4'hB and `single_err`=1.
- **Error in the overall-parity bit:** `ip`=8'hAB gives `par`=4'h8, `data`=4'hB and `single_err`=1.
- **Double error:** `ip`=8'hCA (bits 5 and 6 flipped) gives `par`=4'h3, `data`=4'hD (raw) and `double_err`=1.
- **Exhaustive sweep:** drive all 256 codewords back to back. Compare each result against a behavioural model with one-cycle latency, then repeat the sweep with P_BITS=4 over random codewords.
- **Reset:** assert `rst` mid-sweep, then release it. All outputs must read 0 immediately while in reset. `out_valid` must return to 1 on the first valid edge after release.
